// File: rtl/ram_dp_ctrl.sv
// Simple dual-port synchronous RAM with byte enables, read-during-write policy and clear sweep.
// Define RAM_DP_OUT_REG_EN to add a second read output register (latency 2).
module ram_dp_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter bit RDW_NEW = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? CLEAR : RUN;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  run;
  logic                  rd_go;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (cnt_q == '1) state_d = RUN;
      RUN:   state_d = RUN;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    busy = (state_q == CLEAR);
    run  = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (state_q == CLEAR)
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= INIT_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i])
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign rd_go = rd_en && run;
  assign hit   = wr_en && (wr_addr == rd_addr);

  // Same-address bypass picks written lanes only when the new-data policy is set
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_NEW && hit) begin
      for (int i = 0; i < NB; i++)
        if (wr_be[i])
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_go;
      if (rd_go) rd_q <= rd_word;
    end
  end

`ifdef RAM_DP_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd2_q;
  logic                  vld2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd2_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld_q;
      if (vld_q) rd2_q <= rd_q;
    end
  end

  assign rd_data  = rd2_q;
  assign rd_valid = vld2_q;
`else
  assign rd_data  = rd_q;
  assign rd_valid = vld_q;
`endif

endmodule

// File: tb/tb_ram_dp_ctrl.sv
// Directed bench for ram_dp_ctrl: two instances differing only in read-during-write policy.
// Honours RAM_DP_OUT_REG_EN for read latency.
module tb_ram_dp_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] INIT = 16'hA5A5;
`ifdef RAM_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic          busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_dp_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(1'b0),
    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
  ) dut0 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
  );

  ram_dp_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(1'b1),
    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = 2'b00;
  endtask

  task automatic rd_both(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk({tag, "_vld0"}, 32'(rd_valid0), 32'd1);
    chk({tag, "_dat0"}, 32'(rd_data0), 32'(e0));
    chk({tag, "_vld1"}, 32'(rd_valid1), 32'd1);
    chk({tag, "_dat1"}, 32'(rd_data1), 32'(e1));
  endtask

  task automatic sweep_len(input string tag, input logic req);
    int n;
    int seen_vld;
    n = 0;
    seen_vld = 0;
    wr_en = req; wr_addr = 4'd3; wr_data = 16'h1234; wr_be = {2{req}};
    rd_en = req; rd_addr = 4'd3;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (rd_valid0 || rd_valid1) seen_vld++;
      if (!busy0) break;
    end
    wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;
    chk({tag, "_len"}, 32'(n), 32'd16);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_novld"}, 32'(seen_vld), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_vld", 32'(rd_valid0), 32'd0);
    chk("rst_dat", 32'(rd_data0), 32'd0);
    tick();
    reset_n = 1'b1;

    sweep_len("sweep", 1'b1);

    for (int a = 0; a < 16; a++)
      rd_both($sformatf("clr%0d", a), AW'(a), INIT, INIT);
    rd_both("req_ign", 4'd3, INIT, INIT);

    wr(4'd5, 16'hFFFF, 2'b11);
    wr(4'd5, 16'h0012, 2'b01);
    rd_both("be01", 4'd5, 16'hFF12, 16'hFF12);
    wr(4'd5, 16'h0000, 2'b00);
    rd_both("be00", 4'd5, 16'hFF12, 16'hFF12);

    wr(4'd7, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h2222; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("rdw_old", 32'(rd_data0), 32'h1111);
    chk("rdw_new", 32'(rd_data1), 32'h2211);
    rd_both("rdw_after", 4'd7, 16'h2211, 16'h2211);

    for (int a = 0; a < 4; a++)
      wr(AW'(a), DW'(16'h1000 + a), 2'b11);
    for (int c = 0; c < 4 + LAT; c++) begin
      int k;
      rd_en = (c < 4);
      rd_addr = AW'(c);
      tick();
      k = c - LAT + 1;
      if (k >= 0 && k < 4) begin
        chk($sformatf("strm_vld%0d", k), 32'(rd_valid0), 32'd1);
        chk($sformatf("strm_dat%0d", k), 32'(rd_data0), 32'h1000 + k);
      end else if (k >= 4) begin
        chk("hold_vld", 32'(rd_valid0), 32'd0);
        chk("hold_dat", 32'(rd_data1), 32'h1003);
      end
    end
    rd_en = 1'b0;

    rd_en = 1'b1; rd_addr = 4'd2;
    repeat (LAT) tick();
    chk("pre_arst_vld", 32'(rd_valid0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_run_vld", 32'(rd_valid0), 32'd0);
    chk("arst_run_dat", 32'(rd_data0), 32'd0);
    chk("arst_run_busy", 32'(busy0), 32'd1);
    rd_en = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    wr_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sw_busy", 32'(busy1), 32'd1);
    chk("arst_sw_vld", 32'(rd_valid1), 32'd0);
    chk("arst_sw_dat", 32'(rd_data1), 32'd0);
    tick();
    reset_n = 1'b1;
    sweep_len("resweep", 1'b0);
    rd_both("reclr5", 4'd5, INIT, INIT);
    rd_both("reclr15", 4'd15, INIT, INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
